// File: rtl/ame_sobel_pkg.sv
// Shared types and helpers for the AME Sobel tile engine.
package ame_sobel_pkg;

  typedef enum logic {
    SOBEL_ACROSS = 1'b0,
    SOBEL_ALONG  = 1'b1
  } sobel_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } sobel_state_t;

  // Magnitude of a signed gradient, clamped to maxv.
  function automatic int sat_abs(input int g, input int maxv);
    int a;
    a = (g < 0) ? -g : g;
    return (a > maxv) ? maxv : a;
  endfunction

endpackage

// File: rtl/ame_sobel_array_if.sv
// Line-stream and tile-result bundle between the AME line memories and the Sobel engine.
interface ame_sobel_array_if #(
  parameter int BLK_SIZE       = 4,
  parameter int LINE_DATA_BITS = 7,
  parameter int COMP_DATA_BITS = 8
) ();

  logic                                                  comp_init_i;
  logic                                                  comp_mode_i;
  logic                                                  line_valid_i;
  logic [BLK_SIZE+1:0][LINE_DATA_BITS-1:0]               line_data_i;
  logic                                                  comp_busy_o;
  logic                                                  comp_done_o;
  logic [BLK_SIZE-1:0][BLK_SIZE-1:0][COMP_DATA_BITS-1:0] comp_data_o;

  modport master (
    output comp_init_i, comp_mode_i, line_valid_i, line_data_i,
    input  comp_busy_o, comp_done_o, comp_data_o
  );

  modport slave (
    input  comp_init_i, comp_mode_i, line_valid_i, line_data_i,
    output comp_busy_o, comp_done_o, comp_data_o
  );

endinterface

// File: rtl/ame_sobel_row.sv
// One result row: three consecutive lines in, BLK_SIZE saturated gradient magnitudes out.
module ame_sobel_row
  import ame_sobel_pkg::*;
#(
  parameter int BLK_SIZE       = 4,
  parameter int LINE_DATA_BITS = 7,
  parameter int COMP_DATA_BITS = 8
) (
  input  logic [BLK_SIZE+1:0][LINE_DATA_BITS-1:0] l0_i,
  input  logic [BLK_SIZE+1:0][LINE_DATA_BITS-1:0] l1_i,
  input  logic [BLK_SIZE+1:0][LINE_DATA_BITS-1:0] l2_i,
  input  sobel_mode_t                             mode_i,
  output logic [BLK_SIZE-1:0][COMP_DATA_BITS-1:0] res_o
);

  localparam int MAXV = (1 << COMP_DATA_BITS) - 1;

  for (genvar c = 0; c < BLK_SIZE; c++) begin : g_col
    int s0, s2, d0, d1, d2, g;

    always_comb begin
      s0 = int'(l0_i[c]) + 2 * int'(l0_i[c+1]) + int'(l0_i[c+2]);
      s2 = int'(l2_i[c]) + 2 * int'(l2_i[c+1]) + int'(l2_i[c+2]);
      d0 = int'(l0_i[c+2]) - int'(l0_i[c]);
      d1 = int'(l1_i[c+2]) - int'(l1_i[c]);
      d2 = int'(l2_i[c+2]) - int'(l2_i[c]);
      g  = (mode_i == SOBEL_ACROSS) ? (s2 - s0) : (d0 + 2 * d1 + d2);
    end

    assign res_o[c] = COMP_DATA_BITS'(sat_abs(g, MAXV));
  end

endmodule

// File: rtl/ame_sobel_array.sv
// Streaming Sobel tile engine: collects BLK_SIZE+2 lines and writes one result row per line from line 2 on.
module ame_sobel_array
  import ame_sobel_pkg::*;
#(
  parameter int BLK_SIZE       = 4,
  parameter int LINE_DATA_BITS = 7,
  parameter int COMP_DATA_BITS = 8
) (
  input logic               clk_i,
  input logic               rst_n_i,
  ame_sobel_array_if.slave  bus
);

  localparam int CW = $clog2(BLK_SIZE + 3);

  typedef logic [BLK_SIZE+1:0][LINE_DATA_BITS-1:0]               line_t;
  typedef logic [BLK_SIZE-1:0][BLK_SIZE-1:0][COMP_DATA_BITS-1:0] tile_t;

  sobel_state_t                           state_q, state_d;
  logic [CW-1:0]                          cnt_q, cnt_d;
  line_t                                  l0_q, l0_d, l1_q, l1_d;
  sobel_mode_t                            mode_q, mode_d;
  tile_t                                  data_q, data_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic [BLK_SIZE-1:0][COMP_DATA_BITS-1:0] row_res;

  ame_sobel_row #(
    .BLK_SIZE      (BLK_SIZE),
    .LINE_DATA_BITS(LINE_DATA_BITS),
    .COMP_DATA_BITS(COMP_DATA_BITS)
  ) u_row (
    .l0_i  (l0_q),
    .l1_i  (l1_q),
    .l2_i  (bus.line_data_i),
    .mode_i(mode_q),
    .res_o (row_res)
  );

  // Line 0 lands in L1 so the common shift path moves it to L0 when line 1 arrives.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l0_d    = l0_q;
    l1_d    = l1_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (bus.comp_init_i) begin
      state_d = FILL;
      cnt_d   = CW'(1);
      mode_d  = sobel_mode_t'(bus.comp_mode_i);
      l0_d    = '0;
      l1_d    = bus.line_data_i;
      data_d  = '0;
    end else begin
      case (state_q)
        FILL: if (bus.line_valid_i) begin
          l0_d    = l1_q;
          l1_d    = bus.line_data_i;
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
        RUN: if (bus.line_valid_i) begin
          l0_d  = l1_q;
          l1_d  = bus.line_data_i;
          cnt_d = cnt_q + CW'(1);
          for (int unsigned r = 0; r < BLK_SIZE; r++) begin
            if (cnt_q == CW'(r + 2)) data_d[r] = row_res;
          end
          if (cnt_q == CW'(BLK_SIZE + 1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == FILL) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l0_q    <= '0;
      l1_q    <= '0;
      mode_q  <= SOBEL_ACROSS;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l0_q    <= l0_d;
      l1_q    <= l1_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.comp_busy_o = busy_q;
  assign bus.comp_done_o = done_q;
  assign bus.comp_data_o = data_q;

endmodule
